// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states and
// the result-select code that marks a load in EX.
package hazard_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } fsm_state_e;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
    localparam logic [4:0] REG_ZERO        = 5'd0;

endpackage : hazard_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low reset; holds at all-ones
// instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : sat_counter

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller: load-use detection, multi-cycle FPU sequencing,
// taken-branch flushing and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int FPU_LAT   = 8,
    parameter int CNT_W     = 32,
    parameter int CNT_FPU_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic [4:0]       Rd_E,
    input  logic [1:0]       ResultSrc_E,
    input  logic             RegWrite_E,
    input  logic             RegWriteF_E,
    input  logic             BranchTaken_E,
    input  logic             FpuMulti_E,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             flush_D,
    output logic             flush_E,
    output logic             flush_M,
    output logic             fpu_busy,
    output logic             fpu_done,
    output logic [CNT_W-1:0] stall_cycles
);

    import hazard_pkg::*;

    localparam logic [CNT_FPU_W-1:0] FPU_CNT_INIT = CNT_FPU_W'(FPU_LAT - 2);

    fsm_state_e           state_q, state_d;
    logic [CNT_FPU_W-1:0] fpu_cnt_q, fpu_cnt_d;

    logic lu;
    logic stall_f_c, stall_d_c, stall_e_c;
    logic flush_d_c, flush_e_c, flush_m_c;
    logic busy_c, done_c;

    // x0 is only exempt for integer writes; f0 is a real float register.
    always_comb begin
        lu = (ResultSrc_E == RESULT_SRC_LOAD)
             && ((RegWrite_E && (Rd_E != REG_ZERO)) || RegWriteF_E)
             && ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));
    end

    always_comb begin
        state_d   = state_q;
        fpu_cnt_d = fpu_cnt_q;
        stall_f_c = 1'b0;
        stall_d_c = 1'b0;
        stall_e_c = 1'b0;
        flush_d_c = 1'b0;
        flush_e_c = 1'b0;
        flush_m_c = 1'b0;
        busy_c    = 1'b0;
        done_c    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (BranchTaken_E) begin
                    flush_d_c = 1'b1;
                    flush_e_c = 1'b1;
                end else if (FpuMulti_E) begin
                    stall_f_c = 1'b1;
                    stall_d_c = 1'b1;
                    stall_e_c = 1'b1;
                    flush_m_c = 1'b1;
                    fpu_cnt_d = FPU_CNT_INIT;
                    state_d   = BUSY;
                end else if (lu) begin
                    stall_f_c = 1'b1;
                    stall_d_c = 1'b1;
                    flush_e_c = 1'b1;
                end
            end

            // The op still sitting in EX must not retrigger, so inputs are ignored here.
            BUSY: begin
                busy_c = 1'b1;
                if (fpu_cnt_q != '0) begin
                    stall_f_c = 1'b1;
                    stall_d_c = 1'b1;
                    stall_e_c = 1'b1;
                    flush_m_c = 1'b1;
                    fpu_cnt_d = fpu_cnt_q - CNT_FPU_W'(1);
                end else begin
                    done_c  = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            fpu_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            fpu_cnt_q <= fpu_cnt_d;
        end
    end

    // Outputs are combinational, so gate them with reset to keep them low during reset.
    assign stall_F  = stall_f_c & rst;
    assign stall_D  = stall_d_c & rst;
    assign stall_E  = stall_e_c & rst;
    assign flush_D  = flush_d_c & rst;
    assign flush_E  = flush_e_c & rst;
    assign flush_M  = flush_m_c & rst;
    assign fpu_busy = busy_c & rst;
    assign fpu_done = done_c & rst;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (stall_F),
        .count(stall_cycles)
    );

endmodule : pipeline_hazard_ctrl

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl (FPU_LAT=4, CNT_W=4),
// with a second FPU_LAT=2 instance sharing the same inputs.
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic [7:0] bits;
        logic [3:0] cnt;
        logic       chk2;
        logic [2:0] bits2;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] Rs1_D = '0, Rs2_D = '0, Rd_E = '0;
    logic [1:0] ResultSrc_E = '0;
    logic       RegWrite_E = 1'b0, RegWriteF_E = 1'b0;
    logic       BranchTaken_E = 1'b0, FpuMulti_E = 1'b0;

    logic        stall_F, stall_D, stall_E, flush_D, flush_E, flush_M, fpu_busy, fpu_done;
    logic [3:0]  stall_cycles;
    logic        stall_F2, stall_D2, stall_E2, flush_D2, flush_E2, flush_M2, fpu_busy2, fpu_done2;
    logic [31:0] stall_cycles2;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;
    int   step_no = 0;
    logic [3:0] exp_cnt = '0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.FPU_LAT(4), .CNT_W(4), .CNT_FPU_W(6)) dut (
        .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_E(Rd_E),
        .ResultSrc_E(ResultSrc_E), .RegWrite_E(RegWrite_E), .RegWriteF_E(RegWriteF_E),
        .BranchTaken_E(BranchTaken_E), .FpuMulti_E(FpuMulti_E),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E),
        .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M),
        .fpu_busy(fpu_busy), .fpu_done(fpu_done), .stall_cycles(stall_cycles)
    );

    pipeline_hazard_ctrl #(.FPU_LAT(2), .CNT_W(32), .CNT_FPU_W(6)) dut2 (
        .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_E(Rd_E),
        .ResultSrc_E(ResultSrc_E), .RegWrite_E(RegWrite_E), .RegWriteF_E(RegWriteF_E),
        .BranchTaken_E(BranchTaken_E), .FpuMulti_E(FpuMulti_E),
        .stall_F(stall_F2), .stall_D(stall_D2), .stall_E(stall_E2),
        .flush_D(flush_D2), .flush_E(flush_E2), .flush_M(flush_M2),
        .fpu_busy(fpu_busy2), .fpu_done(fpu_done2), .stall_cycles(stall_cycles2)
    );

    // Expected bit order: {stall_F, stall_D, stall_E, flush_D, flush_E, flush_M, fpu_busy, fpu_done}
    task automatic pushExpected(input logic [7:0] e, input logic c2, input logic [2:0] e2);
        exp_t x;
        x.bits  = e;
        x.cnt   = exp_cnt;
        x.chk2  = c2;
        x.bits2 = e2;
        sb.push_back(x);
        if (e[7]) exp_cnt = (exp_cnt == 4'hF) ? 4'hF : exp_cnt + 4'd1;
    endtask

    task automatic checkOutput();
        exp_t x;
        logic [7:0] obs;
        logic [2:0] obs2;
        x    = sb.pop_front();
        obs  = {stall_F, stall_D, stall_E, flush_D, flush_E, flush_M, fpu_busy, fpu_done};
        obs2 = {stall_F2, fpu_busy2, fpu_done2};
        step_no++;
        compared++;
        assert (obs === x.bits) else begin
            mismatched++;
            $error("[TB] FAIL step%0d outputs observed=%b expected=%b", step_no, obs, x.bits);
        end
        compared++;
        assert (stall_cycles === x.cnt) else begin
            mismatched++;
            $error("[TB] FAIL step%0d stall_cycles observed=%0d expected=%0d", step_no, stall_cycles, x.cnt);
        end
        if (x.chk2) begin
            compared++;
            assert (obs2 === x.bits2) else begin
                mismatched++;
                $error("[TB] FAIL step%0d lat2 {stall_F,busy,done} observed=%b expected=%b", step_no, obs2, x.bits2);
            end
        end
    endtask

    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic [1:0] src, input logic rw, input logic rwf,
                                 input logic br, input logic fm,
                                 input logic [7:0] e, input logic c2, input logic [2:0] e2);
        @(posedge clk);
        #1;
        Rs1_D = rs1; Rs2_D = rs2; Rd_E = rd; ResultSrc_E = src;
        RegWrite_E = rw; RegWriteF_E = rwf; BranchTaken_E = br; FpuMulti_E = fm;
        pushExpected(e, c2, e2);
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        // Reset held with a branch+load-use on the inputs: everything must stay low.
        Rs1_D = 5'd5; Rd_E = 5'd5; ResultSrc_E = 2'b01; RegWrite_E = 1'b1; BranchTaken_E = 1'b1;
        #2;
        pushExpected(8'b0000_0000, 1'b1, 3'b000);
        checkOutput();
        @(posedge clk); #1 rst = 1'b1;

        // Load-use on rs1, then the load has moved on
        applyStimulus(5'd5, 5'd0, 5'd5, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 8'b1100_1000, 1'b1, 3'b100);
        applyStimulus(5'd5, 5'd0, 5'd5, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0000, 1'b1, 3'b000);
        // Integer load to x0: exempt; float load to f0: stalls
        applyStimulus(5'd3, 5'd0, 5'd0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 8'b0000_0000, 1'b0, 3'b000);
        applyStimulus(5'd3, 5'd0, 5'd0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 8'b1100_1000, 1'b0, 3'b000);
        applyStimulus(5'd3, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0000, 1'b0, 3'b000);
        // Branch wins over load-use and over an FPU start
        applyStimulus(5'd7, 5'd1, 5'd7, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 8'b0001_1000, 1'b1, 3'b000);
        applyStimulus(5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 8'b0001_1000, 1'b0, 3'b000);
        // FPU_LAT=4 op held 4 cycles; branch+load-use in BUSY ignored
        applyStimulus(5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'b1110_0100, 1'b0, 3'b000);
        applyStimulus(5'd3, 5'd2, 5'd3, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 8'b1110_0110, 1'b0, 3'b000);
        applyStimulus(5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'b1110_0110, 1'b0, 3'b000);
        applyStimulus(5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'b0000_0011, 1'b0, 3'b000);
        applyStimulus(5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0000, 1'b1, 3'b000);
        // Two-cycle op: FPU_LAT=2 instance finishes on cycle 2, main instance keeps going
        applyStimulus(5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'b1110_0100, 1'b1, 3'b100);
        applyStimulus(5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'b1110_0110, 1'b1, 3'b011);
        applyStimulus(5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'b1110_0110, 1'b1, 3'b000);
        applyStimulus(5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0011, 1'b1, 3'b000);
        applyStimulus(5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0000, 1'b0, 3'b000);
        // Asynchronous reset in the second BUSY cycle
        applyStimulus(5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'b1110_0100, 1'b0, 3'b000);
        applyStimulus(5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'b1110_0110, 1'b0, 3'b000);
        @(posedge clk);
        #1;
        pushExpected(8'b1110_0110, 1'b0, 3'b000);
        #2;
        checkOutput();
        rst = 1'b0;
        exp_cnt = '0;
        #1;
        pushExpected(8'b0000_0000, 1'b1, 3'b000);
        checkOutput();
        @(posedge clk); #1 rst = 1'b1; FpuMulti_E = 1'b0;
        applyStimulus(5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0000, 1'b1, 3'b000);
        // Twenty back-to-back load-use stalls saturate the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            applyStimulus(5'd9, 5'd4, 5'd4, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 8'b1100_1000, 1'b0, 3'b000);
        end
        applyStimulus(5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0000, 1'b0, 3'b000);
        applyStimulus(5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0000, 1'b0, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_pipeline_hazard_ctrl
